// File: rtl/piece_plotter_pkg.sv
// piece_plotter_pkg
//   Shared types and constants for the piece plotter block.
//   - state_e          : plotter FSM states (IDLE, DRAW, DONE)
//   - VGA_X_W/VGA_Y_W  : VGA adapter coordinate widths
//   - COLOUR_W         : VGA colour width
//   - BLACK/GREEN/WHITE: common 3-bit VGA colours
package piece_plotter_pkg;

    localparam int unsigned VGA_X_W  = 8;
    localparam int unsigned VGA_Y_W  = 7;
    localparam int unsigned COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] GREEN = 3'b010;
    localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/tile_scan_counter.sv
// tile_scan_counter
//   Row-major (cx, cy) walker over a TILE x TILE square.
//   Ports:
//     clk    in  : clock, rising edge
//     rst    in  : asynchronous active-high reset
//     clr_i  in  : synchronous clear of both counters (wins over en_i)
//     en_i   in  : advance one pixel
//     cx_o   out : current column
//     cy_o   out : current row
//     last_o out : high at (TILE-1, TILE-1)
module tile_scan_counter #(
    parameter int unsigned TILE = 4,
    parameter int unsigned CW   = (TILE > 1) ? $clog2(TILE) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cx_o,
    output logic [CW-1:0] cy_o,
    output logic          last_o
);

    localparam logic [CW-1:0] CMax = CW'(TILE - 1);

    logic [CW-1:0] cx_q, cx_d;
    logic [CW-1:0] cy_q, cy_d;

    assign last_o = (cx_q == CMax) && (cy_q == CMax);
    assign cx_o   = cx_q;
    assign cy_o   = cy_q;

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (clr_i) begin
            cx_d = '0;
            cy_d = '0;
        end else if (en_i) begin
            if (cx_q == CMax) begin
                cx_d = '0;
                // Explicit wrap: TILE need not be a power of two.
                cy_d = (cy_q == CMax) ? '0 : cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

endmodule

// File: rtl/piece_plotter.sv
// piece_plotter
//   Draws one filled TILE x TILE square on the VGA frame buffer, one pixel
//   write per cycle in row-major order, then pulses done for one cycle.
//   Optional build macro: PIECE_PLOTTER_BORDER_EN -- edge pixels of the tile
//   are written with BORDER_COLOUR instead of the latched colour.
//   Ports:
//     clk        in  : clock, rising edge
//     resetn     in  : asynchronous reset, ACTIVE HIGH despite the name
//     start      in  : draw request, sampled only in IDLE
//     base_x     in  : tile top-left pixel X
//     base_y     in  : tile top-left pixel Y
//     colour     in  : piece colour
//     busy       out : high in DRAW and DONE (registered)
//     done       out : one-cycle completion pulse
//     plot       out : VGA adapter write enable
//     vga_x      out : pixel X (wraps mod 256)
//     vga_y      out : pixel Y (wraps mod 128)
//     vga_colour out : pixel colour
module piece_plotter
    import piece_plotter_pkg::*;
#(
    parameter int unsigned         TILE          = 4,
    parameter logic [COLOUR_W-1:0] BORDER_COLOUR = GREEN
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [VGA_X_W-1:0]  base_x,
    input  logic [VGA_Y_W-1:0]  base_y,
    input  logic [COLOUR_W-1:0] colour,
    output logic                busy,
    output logic                done,
    output logic                plot,
    output logic [VGA_X_W-1:0]  vga_x,
    output logic [VGA_Y_W-1:0]  vga_y,
    output logic [COLOUR_W-1:0] vga_colour
);

    localparam int unsigned CW = (TILE > 1) ? $clog2(TILE) : 1;

    state_e                state_q;
    logic [VGA_X_W-1:0]    bx_q;
    logic [VGA_Y_W-1:0]    by_q;
    logic [COLOUR_W-1:0]   col_q;
    logic                  busy_q, done_q, plot_q;
    logic [VGA_X_W-1:0]    vga_x_q;
    logic [VGA_Y_W-1:0]    vga_y_q;
    logic [COLOUR_W-1:0]   vga_col_q;

    logic                  cnt_clr, cnt_en, cnt_last;
    logic [CW-1:0]         cx, cy;
    logic [COLOUR_W-1:0]   pix_colour;

    assign cnt_clr = (state_q == IDLE) && start;
    assign cnt_en  = (state_q == DRAW);

    tile_scan_counter #(
        .TILE (TILE),
        .CW   (CW)
    ) u_scan (
        .clk    (clk),
        .rst    (resetn),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .cx_o   (cx),
        .cy_o   (cy),
        .last_o (cnt_last)
    );

`ifdef PIECE_PLOTTER_BORDER_EN
    localparam logic [CW-1:0] CMax = CW'(TILE - 1);
    logic is_border;
    assign is_border  = (cx == '0) || (cx == CMax) || (cy == '0) || (cy == CMax);
    assign pix_colour = is_border ? BORDER_COLOUR : col_q;
`else
    logic unused_border;
    assign unused_border = ^BORDER_COLOUR;
    assign pix_colour    = col_q;
`endif

    // Single-process FSM; every output is a register updated from state_q.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q   <= IDLE;
            bx_q      <= '0;
            by_q      <= '0;
            col_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            plot_q    <= 1'b0;
            vga_x_q   <= '0;
            vga_y_q   <= '0;
            vga_col_q <= BLACK;
        end else begin
            unique case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    plot_q <= 1'b0;
                    if (start) begin
                        bx_q    <= base_x;
                        by_q    <= base_y;
                        col_q   <= colour;
                        state_q <= DRAW;
                    end
                end
                DRAW: begin
                    busy_q    <= 1'b1;
                    done_q    <= 1'b0;
                    plot_q    <= 1'b1;
                    vga_x_q   <= bx_q + VGA_X_W'(cx);
                    vga_y_q   <= by_q + VGA_Y_W'(cy);
                    vga_col_q <= pix_colour;
                    if (cnt_last) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b1;
                    done_q  <= 1'b1;
                    plot_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign plot       = plot_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_col_q;

endmodule

// File: tb/tb_piece_plotter.sv
// tb_piece_plotter
//   Directed bench for piece_plotter (TILE=4). Observed outputs are packed as
//   {busy, done, plot, vga_x, vga_y, vga_colour} and compared once per cycle.
//   Honours PIECE_PLOTTER_BORDER_EN for the expected pixel colours.
module tb_piece_plotter;

    localparam int unsigned TILE = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [2:0] colour;
    logic       busy, done, plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int n_vec = 0;
    int n_err = 0;

    // Last written pixel, which the outputs must hold while plot=0.
    logic [7:0] last_x;
    logic [6:0] last_y;
    logic [2:0] last_c;

    piece_plotter #(
        .TILE          (TILE),
        .BORDER_COLOUR (3'b010)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .base_x     (base_x),
        .base_y     (base_y),
        .colour     (colour),
        .busy       (busy),
        .done       (done),
        .plot       (plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] obs();
        return {busy, done, plot, vga_x, vga_y, vga_colour};
    endfunction

    task automatic check_eq(input string tag, input logic [20:0] got, input logic [20:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got b/d/p=%b%b%b x=%0d y=%0d c=%b, expected b/d/p=%b%b%b x=%0d y=%0d c=%b",
                     tag, got[20], got[19], got[18], got[17:10], got[9:3], got[2:0],
                     exp[20], exp[19], exp[18], exp[17:10], exp[9:3], exp[2:0]);
        end
    endtask

    function automatic logic [2:0] exp_colour(input int cx, input int cy, input logic [2:0] col);
`ifdef PIECE_PLOTTER_BORDER_EN
        if (cx == 0 || cx == TILE - 1 || cy == 0 || cy == TILE - 1) return 3'b010;
        return col;
`else
        if (cx < 0 || cy < 0) return 3'b000;
        return col;
`endif
    endfunction

    // Called #1 after a posedge with the DUT in IDLE; start is sampled at the
    // next edge (edge 0). With poke set, start is re-raised for edges 5 and 17.
    task automatic draw_tile(input string name, input logic [7:0] bx, input logic [6:0] by,
                             input logic [2:0] col, input bit poke);
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        base_x = bx;
        base_y = by;
        colour = col;
        start  = 1'b1;
        @(posedge clk); #1;
        check_eq($sformatf("%s e0", name), obs(), {3'b000, last_x, last_y, last_c});
        // Input changes after the start edge must not disturb the tile.
        start  = 1'b0;
        base_x = 8'd40;
        base_y = 7'd40;
        colour = 3'b001;
        for (int k = 1; k <= TILE * TILE + 1; k++) begin
            if (poke) start = (k == 5 || k == TILE * TILE + 1);
            @(posedge clk); #1;
            if (k <= TILE * TILE) begin
                ex = bx + 8'((k - 1) % TILE);
                ey = by + 7'((k - 1) / TILE);
                ec = exp_colour((k - 1) % TILE, (k - 1) / TILE, col);
                check_eq($sformatf("%s e%0d", name, k), obs(), {3'b101, ex, ey, ec});
                last_x = ex;
                last_y = ey;
                last_c = ec;
            end else begin
                check_eq($sformatf("%s done e%0d", name, k), obs(), {3'b110, last_x, last_y, last_c});
            end
        end
        start = 1'b0;
    endtask

    initial begin
        resetn = 1'b1;
        start  = 1'b0;
        base_x = '0;
        base_y = '0;
        colour = '0;
        last_x = '0;
        last_y = '0;
        last_c = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset", obs(), 21'd0);
        resetn = 1'b0;
        @(posedge clk); #1;
        check_eq("post-reset idle", obs(), 21'd0);

        // Full tile with lockout pokes, then earliest restart with wrap-around.
        draw_tile("full", 8'd8, 7'd12, 3'b111, 1'b1);
        draw_tile("wrap", 8'd254, 7'd126, 3'b101, 1'b0);

        // Reset at the 7th plot.
        base_x = 8'd20;
        base_y = 7'd30;
        colour = 3'b011;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            check_eq($sformatf("mid e%0d", k), obs(),
                     {3'b101, 8'(20 + (k - 1) % TILE), 7'(30 + (k - 1) / TILE), 3'b011});
        end
        resetn = 1'b1;
        #1;
        check_eq("mid async reset", obs(), 21'd0);
        @(posedge clk); #1;
        resetn = 1'b0;
        last_x = '0;
        last_y = '0;
        last_c = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            check_eq($sformatf("mid quiet %0d", k), obs(), 21'd0);
        end

        // Fresh tile after the abort; black exercises the border colouring.
        draw_tile("border", 8'd0, 7'd0, 3'b000, 1'b0);
        @(posedge clk); #1;
        check_eq("final idle", obs(), {3'b000, last_x, last_y, last_c});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/piece_plotter.md
# piece_plotter

Draws one board piece as a filled TILE×TILE pixel square on the VGA frame buffer. It sits directly downstream of the piece-coordinate stage, which converts a board cell into a pixel origin and a 3-bit VGA colour. The block latches that origin and colour on a start pulse, then walks every pixel of the tile, issuing one VGA adapter write per cycle. It signals completion with a one-cycle done pulse.

## Interface
- TILE, 4: tile edge in pixels; legal values 2..16.
- BORDER_COLOUR, 3'b010: border pixel colour, used only when the border feature is compiled in.
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-high reset. The name is kept for codebase consistency; logic 1 means reset.
- start  in  1  request to draw one tile; sampled only in IDLE.
- base_x  in  8  pixel X of the tile's top-left corner.
- base_y  in  7  pixel Y of the tile's top-left corner.
- colour  in  3  piece colour.
- busy  out  1  high in DRAW and DONE.
- done  out  1  one-cycle pulse after the last pixel is written.
- plot  out  1  VGA adapter write enable.
- vga_x  out  8  pixel X being written.
- vga_y  out  7  pixel Y being written.
- vga_colour  out  3  colour being written.

## Operation
- States:
  - IDLE: waiting for a request.
  - DRAW: writing pixels.
  - DONE: signalling completion.
- IDLE to DRAW:
  - Occurs when start=1.
  - base_x, base_y and colour are latched.
  - Column counter cx and row counter cy are cleared to 0.
- DRAW behaviour, each cycle:
  - plot=1, vga_x=base_x+cx, vga_y=base_y+cy, vga_colour=latched colour.
  - cx increments. When cx=TILE-1, cx wraps to 0 and cy increments.
  - Scan order is row-major, left to right, top to bottom.
- DRAW to DONE: after the cycle that writes (cx,cy)=(TILE-1,TILE-1).
- DONE behaviour: done=1, plot=0. The next state is always IDLE.
- start is ignored while in DRAW or DONE. A request is never queued.
- Input changes after the start cycle have no effect on a tile in progress.
- Address arithmetic:
  - vga_x is the sum truncated to 8 bits; vga_y is the sum truncated to 7 bits.
  - Overflow wraps modulo 256 and 128 respectively, with no saturation and no suppression.
- Outputs are registered.
  - vga_x, vga_y and vga_colour hold their last value whenever plot=0.
- Reset (asynchronous, any state, including mid-tile):
  - State returns to IDLE; cx and cy clear to 0.
  - busy=0, done=0, plot=0, vga_x=0, vga_y=0, vga_colour=3'b000.
  - A partially drawn tile is abandoned.

## Timing
- start sampled high at edge 0: first plot at edge 1, last plot at edge TILE², done at edge TILE²+1.
- For TILE=4: 16 plot cycles, done at edge 17, IDLE again at edge 18.
- The earliest accepted restart is a start sampled at edge 18.
- Back-to-back throughput is one tile per TILE²+2 cycles.
- busy rises at edge 1 and falls at edge TILE²+2.

## Configuration
- PIECE_PLOTTER_BORDER_EN defined:
  - A pixel is a border pixel when cx or cy equals 0 or TILE-1.
  - Border pixels are written with BORDER_COLOUR; interior pixels use the latched colour.
  - With TILE=2, every pixel is a border pixel.
- PIECE_PLOTTER_BORDER_EN undefined:
  - All pixels use the latched colour.
  - BORDER_COLOUR is unused.
- Timing is identical in both builds.

## Structure
- piece_plotter_pkg holds:
  - The state enum (IDLE, DRAW, DONE).
  - VGA_X_W=8, VGA_Y_W=7, COLOUR_W=3.
  - The colour constants BLACK=3'b000, GREEN=3'b010, WHITE=3'b111.
- One sub-module, tile_scan_counter, contains:
  - The cx/cy row-major counter with clear and enable inputs.
  - A last output that is high at (TILE-1,TILE-1).
- The parent owns the FSM, the input latches and the output registers.

## Test plan
- Full tile: reset, then start with base (8,12) and colour 3'b111, TILE=4. Expect exactly 16 plot pulses covering x 8..11, y 12..15 in row-major order, all with colour 111. done goes high at edge 17.
- Busy lockout: pulse start again at edges 5 and 17 with base (40,40). Expect no extra plots and no change to the tile being drawn. The next tile is accepted only on a start at edge 18 or later.
- Wrap-around: base (254,126). Expect vga_x sequence 254,255,0,1 and vga_y rows 126,127,0,1, with no suppression.
- Reset mid-tile: assert resetn at the 7th plot. Expect all outputs 0 and state IDLE immediately, and no done pulse. A later start draws a full 16-pixel tile.
- Border build: with PIECE_PLOTTER_BORDER_EN defined and colour 3'b000, expect the 12 edge pixels as 010 and the 4 interior pixels (1..2,1..2) as 000. Without the macro, expect all 16 pixels as 000.
